data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Word-addressed data memory that answers load/store requests issued by the MEM pipeline stage. It accepts one request at a time over a valid/ready request channel and returns the result over a valid/ready response channel after a configurable fixed latency, so the pipeline can stall on multi-cycle memory. It sits between the MEM stage (initiator) and the rest of the design as the memory-side end of the load/store interface.

## Interface

Parameters:
- ADDR_WIDTH, default 8: word-index width; depth = 2^ADDR_WIDTH 32-bit words.
- LATENCY, default 2: cycles from request acceptance to response valid; legal range ≥ 1.

Ports:
- clock  in  1  single clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; forces FSM to IDLE and outputs to reset values.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- resp_valid  out  1  response present; held until accepted.
- resp_ready  in  1  initiator accepts response.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_error  out  1  request was misaligned or out of range.
- busy  out  1  FSM not in IDLE.

## Operation

- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On an edge with req_valid=1: latch req_write, req_addr, req_wdata; load cnt = LATENCY-1; go to WAIT. Request inputs are ignored in all other states.
- WAIT: if cnt≠0, decrement. If cnt=0, at the next edge perform the access, register the response, and go to RESP.
- Access:
  - Error if req_addr[1:0]≠0 or req_addr[31:ADDR_WIDTH+2]≠0.
  - Error: no memory update, resp_rdata=0, resp_error=1.
  - Load: resp_rdata = mem[req_addr[ADDR_WIDTH+1:2]], resp_error=0.
  - Store: mem[index] = req_wdata, resp_rdata=0, resp_error=0.
- RESP: resp_valid=1. resp_rdata and resp_error are stable while resp_ready=0. On an edge with resp_ready=1: clear resp_valid, resp_rdata, resp_error; go to IDLE.
- busy = (state≠IDLE). req_ready = (state=IDLE).
- resp_valid, resp_rdata and resp_error are registered outputs. req_ready and busy are decoded from state.
- Reset values:
  - state=IDLE, cnt=0.
  - resp_valid=0, resp_rdata=0, resp_error=0.
  - req_ready=1, busy=0.
- Memory array is not cleared by reset. A store is committed only at the WAIT→RESP edge.

## Timing

- Request accepted at edge T (req_valid & req_ready).
- resp_valid rises after edge T+LATENCY. With LATENCY=1, WAIT lasts one cycle.
- Response accepted at edge R (resp_valid & resp_ready). req_ready is high after R.
- The earliest next acceptance is edge R+1. Back-to-back throughput is one request per LATENCY+2 cycles with resp_ready tied high.
- Reset mid-WAIT: the pending store is discarded and memory is unchanged. The FSM returns to IDLE immediately (asynchronously).
- Reset mid-RESP: the response is dropped and the store, already committed, remains.
- A load following a store to the same address returns the new data, because the commit precedes the next acceptance.

## Test plan

- Store / load round trip, LATENCY=2:
  - Store addr 8, wdata 12345 accepted at T → resp_valid at T+2, resp_error=0, resp_rdata=0.
  - Then load addr 8 → resp_rdata=12345, resp_error=0.
- Misaligned load addr 6 → resp_error=1, resp_rdata=0. Latency unchanged (2 cycles).
- Out-of-range store addr 0x400 (ADDR_WIDTH=8), wdata 0xFFFFFFFF → resp_error=1. A subsequent load of addr 0 returns the prior value (0x00000077, stored earlier).
- Response backpressure: load addr 8 with resp_ready=0 for 3 cycles → resp_valid=1, resp_rdata=12345 stable, req_ready=0, busy=1. A new req_valid during these cycles is ignored. After resp_ready=1 for one edge, resp_valid=0 and req_ready=1.
- Reset mid-operation:
  - Store addr 16, value 0x11 completes.
  - Store addr 16, value 0xDEADBEEF; assert reset during WAIT → resp_valid=0, resp_rdata=0, resp_error=0, req_ready=1 immediately.
  - Load addr 16 → 0x11.
- Streaming, LATENCY=1, req_valid and resp_ready held high:
  - Loads of addrs 8 then 16 → acceptances 3 cycles apart.
  - Responses 12345 then 0x11, each resp_valid high exactly one cycle.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed load/store memory. It answers one request at a time, LATENCY cycles after acceptance.
// It holds the response until the initiator accepts it, and refuses new requests while busy.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        busy
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic                  lat_write;
  logic [31:0]           lat_addr;
  logic [31:0]           lat_wdata;
  logic                  addr_err;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  access;

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  assign addr_err  = (lat_addr[1:0] != 2'b00) || ((lat_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  assign idx       = lat_addr[ADDR_WIDTH+1:2];
  assign access    = (state == WAIT) && (cnt == '0);
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // The array has no reset. A store lands only on the WAIT->RESP edge,
  // so a reset during WAIT drops the pending store.
  always_ff @(posedge clock) begin
    if (access && lat_write && !addr_err) begin
      mem[idx] <= lat_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            cnt       <= CW'(LATENCY - 1);
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_error <= addr_err;
            resp_rdata <= (addr_err || lat_write) ? 32'd0 : mem[idx];
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder. A LATENCY=2 instance and a LATENCY=1 instance share their inputs.
// The checks follow the LATENCY=2 instance, except the streaming phase, which checks the LATENCY=1 instance.
module tb_data_mem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;

  logic        a_req_ready, a_resp_valid, a_resp_error, a_busy;
  logic [31:0] a_resp_rdata;
  logic        b_req_ready, b_resp_valid, b_resp_error, b_busy;
  logic [31:0] b_resp_rdata;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(2)) dut_a (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(a_req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready),
    .resp_rdata(a_resp_rdata), .resp_error(a_resp_error), .busy(a_busy)
  );

  data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) dut_b (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(b_req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready),
    .resp_rdata(b_resp_rdata), .resp_error(b_resp_error), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request, let it be accepted, then wait for the instance-A response.
  task automatic issue(input string tag, input logic w, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    check({tag, "_rdy"}, {31'd0, a_req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = addr;
    req_wdata = wd;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!a_resp_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, 32'd2);
    check({tag, "_rdata"}, a_resp_rdata, exp_rdata);
    check({tag, "_err"}, {31'd0, a_resp_error}, {31'd0, exp_err});
  endtask

  task automatic accept(input string tag);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, "_vld_clr"}, {31'd0, a_resp_valid}, 32'd0);
    check({tag, "_rdata_clr"}, a_resp_rdata, 32'd0);
    check({tag, "_rdy_back"}, {31'd0, a_req_ready}, 32'd1);
  endtask

  initial begin
    logic exp_vld [6];
    logic exp_rdy [6];
    logic [31:0] exp_dat [6];

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b0;
    tick();
    tick();
    check("rst_vld",   {31'd0, a_resp_valid}, 32'd0);
    check("rst_rdata", a_resp_rdata, 32'd0);
    check("rst_err",   {31'd0, a_resp_error}, 32'd0);
    check("rst_rdy",   {31'd0, a_req_ready}, 32'd1);
    check("rst_busy",  {31'd0, a_busy}, 32'd0);
    reset = 1'b0;
    tick();

    // Round trip, plus the addr 0 seed value used by the out-of-range test.
    issue("st0", 1'b1, 32'd0, 32'h0000_0077, 32'd0, 1'b0);
    accept("st0");
    issue("st8", 1'b1, 32'd8, 32'd12345, 32'd0, 1'b0);
    accept("st8");
    issue("ld8", 1'b0, 32'd8, 32'd0, 32'd12345, 1'b0);
    accept("ld8");

    issue("mis6", 1'b0, 32'd6, 32'd0, 32'd0, 1'b1);
    accept("mis6");

    issue("oor", 1'b1, 32'h400, 32'hFFFF_FFFF, 32'd0, 1'b1);
    accept("oor");
    issue("ld0", 1'b0, 32'd0, 32'd0, 32'h0000_0077, 1'b0);
    accept("ld0");

    // Backpressure. A competing store request is held high while the response waits.
    issue("bp", 1'b0, 32'd8, 32'd0, 32'd12345, 1'b0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'd16;
    req_wdata = 32'h0000_0BAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_vld",   {31'd0, a_resp_valid}, 32'd1);
      check("bp_rdata", a_resp_rdata, 32'd12345);
      check("bp_rdy",   {31'd0, a_req_ready}, 32'd0);
      check("bp_busy",  {31'd0, a_busy}, 32'd1);
    end
    req_valid = 1'b0;
    accept("bp");

    // Reset while a store is waiting.
    issue("st16", 1'b1, 32'd16, 32'h0000_0011, 32'd0, 1'b0);
    accept("st16");
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'd16;
    req_wdata = 32'hDEAD_BEEF;
    tick();
    req_valid = 1'b0;
    check("mid_busy", {31'd0, a_busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("mr_vld",   {31'd0, a_resp_valid}, 32'd0);
    check("mr_rdata", a_resp_rdata, 32'd0);
    check("mr_err",   {31'd0, a_resp_error}, 32'd0);
    check("mr_rdy",   {31'd0, a_req_ready}, 32'd1);
    check("mr_b_rdy", {31'd0, b_req_ready}, 32'd1);
    tick();
    reset = 1'b0;
    tick();
    issue("ld16", 1'b0, 32'd16, 32'd0, 32'h0000_0011, 1'b0);
    accept("ld16");

    // Streaming on the LATENCY=1 instance, with both handshakes held high.
    exp_vld = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_dat = '{32'd0, 32'd12345, 32'd0, 32'd0, 32'h11, 32'd0};
    check("str_b_rdy0", {31'd0, b_req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 32'd8;
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) req_addr = 32'd16;
      check($sformatf("str_vld%0d", i), {31'd0, b_resp_valid}, {31'd0, exp_vld[i]});
      check($sformatf("str_rdy%0d", i), {31'd0, b_req_ready}, {31'd0, exp_rdy[i]});
      check($sformatf("str_dat%0d", i), b_resp_rdata, exp_dat[i]);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("end_a_idle", {31'd0, a_req_ready}, 32'd1);
    check("end_b_idle", {31'd0, b_req_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
